saturn_fetch_unit: RTL and testbench

//  Instruction-fetch bus front end; replaces the core's test ROM.
//  - Owns the PC.
//  - Issues LOAD_PC and PC_READ commands on the nibble-wide HP48 bus.
//  - Delivers one opcode nibble per CPU cycle to saturn_decoder (i_nibble/i_pc/i_stalled).
//  - Driven by the core's phase enables: en_bus_send = phase 0, en_bus_recv = phase 1.
//  - Accepts PC jumps from the execute stage.

---
 rtl/saturn_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_saturn_fetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_fetch_unit.sv
// saturn_fetch_unit -- instruction-fetch front end on the nibble-wide HP48 bus.
// Owns the PC, issues LOAD_PC / PC_READ commands in phase-0 issue slots,
// captures the returned nibble in phase-1 capture slots and hands it to the
// decoder together with its address.
// Optional feature macro: FETCH_BUSERR_EN (sticky bus-error flag, fetch freeze).

module saturn_fetch_unit #(
    parameter logic [19:0] RESET_PC  = 20'h00000,
    parameter logic [3:0]  CMD_PC_RD = 4'h0,
    parameter logic [3:0]  CMD_LD_PC = 4'h4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en_bus_send,
    input  logic        i_en_bus_recv,
    input  logic        i_inc_pc,
    input  logic        i_stall,
    input  logic        i_load_pc,
    input  logic [19:0] i_new_pc,
    input  logic [3:0]  i_bus_nibble_in,
    input  logic        i_bus_error,
    output logic        o_bus_strobe,
    output logic [3:0]  o_bus_cmd,
    output logic [3:0]  o_bus_nibble_out,
    output logic [19:0] o_pc,
    output logic [3:0]  o_nibble,
    output logic        o_nibble_valid,
    output logic        o_stalled,
    output logic        o_fetch_error
);

    typedef enum logic [1:0] {ST_CMD, ST_ADDR, ST_FIRST, ST_RUN} state_t;

    state_t      state, state_nx;
    logic [19:0] pc, pc_nx;
    logic [2:0]  addr_cnt, addr_cnt_nx;
    logic        pending_jump;
    logic        read_inflight;
    logic        read_issue;
    logic        slot_taken;
    logic        frozen;
    logic        bus_fault;

    // Issue-slot decode: next state, PC update and the bus command of this cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nx         = state;
        pc_nx            = pc;
        addr_cnt_nx      = addr_cnt;
        o_bus_strobe     = 1'b0;
        o_bus_cmd        = 4'h0;
        o_bus_nibble_out = 4'h0;
        read_issue       = 1'b0;
        slot_taken       = 1'b0;

        if (i_en_bus_send && !i_reset && !frozen) begin
            slot_taken = 1'b1;
            if (pending_jump) begin
                // The jump slot itself is silent; the LOAD_PC sequence starts next slot.
                state_nx = ST_CMD;
            end else begin
                case (state)
                    ST_CMD: begin
                        o_bus_strobe = 1'b1;
                        o_bus_cmd    = CMD_LD_PC;
                        addr_cnt_nx  = 3'd0;
                        state_nx     = ST_ADDR;
                    end
                    ST_ADDR: begin
                        // Address goes out low nibble first, five nibbles in total.
                        o_bus_strobe     = 1'b1;
                        o_bus_cmd        = CMD_LD_PC;
                        o_bus_nibble_out = pc[{addr_cnt, 2'b00} +: 4];
                        addr_cnt_nx      = addr_cnt + 3'd1;
                        if (addr_cnt == 3'd4) begin
                            state_nx = ST_FIRST;
                        end
                    end
                    ST_FIRST: begin
                        // Slave already points at pc, so no increment for the first read.
                        o_bus_strobe = 1'b1;
                        o_bus_cmd    = CMD_PC_RD;
                        read_issue   = 1'b1;
                        state_nx     = ST_RUN;
                    end
                    ST_RUN: begin
                        // Slave auto-increments on every PC_READ; pc follows it.
                        if (i_inc_pc && !i_stall) begin
                            pc_nx        = pc + 20'd1;
                            o_bus_strobe = 1'b1;
                            o_bus_cmd    = CMD_PC_RD;
                            read_issue   = 1'b1;
                        end
                    end
                endcase
            end
        end

        // A jump overrides any increment; the last target before a slot wins.
        if (i_load_pc) begin
            pc_nx = i_new_pc;
        end
    end

    // State, PC, jump bookkeeping and nibble capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= ST_CMD;
            pc             <= RESET_PC;
            addr_cnt       <= 3'd0;
            pending_jump   <= 1'b0;
            read_inflight  <= 1'b0;
            o_pc           <= RESET_PC;
            o_nibble       <= 4'h0;
            o_nibble_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge values of the others.
            state          <= state_nx;
            pc             <= pc_nx;
            addr_cnt       <= addr_cnt_nx;
            o_nibble_valid <= 1'b0;

            if (i_load_pc) begin
                pending_jump <= 1'b1;
            end else if (slot_taken) begin
                pending_jump <= 1'b0;
            end

            // A jump discards any read still in flight, so it never produces a pulse.
            if (i_load_pc) begin
                read_inflight <= 1'b0;
            end else if (read_issue) begin
                read_inflight <= 1'b1;
            end else if (i_en_bus_recv && read_inflight) begin
                read_inflight <= 1'b0;
                if (!bus_fault) begin
                    o_nibble       <= i_bus_nibble_in;
                    o_pc           <= pc;
                    o_nibble_valid <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_BUSERR_EN
    logic fetch_error_q;
    logic frozen_q;

    assign bus_fault = i_bus_error;

    // Sticky error flag plus fetch freeze; a later jump releases only the freeze.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_error_q <= 1'b0;
            frozen_q      <= 1'b0;
        end else begin
            if (i_en_bus_recv && i_bus_error) begin
                fetch_error_q <= 1'b1;
                frozen_q      <= 1'b1;
            end
            if (i_load_pc) begin
                frozen_q <= 1'b0;
            end
        end
    end

    assign frozen        = frozen_q;
    assign o_fetch_error = fetch_error_q;
`else
    logic unused_bus_error;

    assign unused_bus_error = i_bus_error;
    assign bus_fault        = 1'b0;
    assign frozen           = 1'b0;
    assign o_fetch_error    = 1'b0;
`endif

    assign o_stalled = (state != ST_RUN) | i_stall | pending_jump | frozen;

endmodule

// File: tb/tb_saturn_fetch_unit.sv
// tb_saturn_fetch_unit -- drives the fetch unit one CPU cycle (4 clocks,
// phases 0..3) at a time. A behavioural bus slave answers reads from a
// synthetic memory; a reference model predicts the fetched address stream
// and a monitor compares every valid nibble against the expectation queue.

module tb_saturn_fetch_unit;

    localparam logic [19:0] RESET_PC = 20'h00000;
    localparam logic [3:0]  CMD_RD   = 4'h0;
    localparam logic [3:0]  CMD_LD   = 4'h4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en_bus_send;
    logic        i_en_bus_recv;
    logic        i_inc_pc;
    logic        i_stall;
    logic        i_load_pc;
    logic [19:0] i_new_pc;
    logic [3:0]  i_bus_nibble_in;
    logic        i_bus_error;
    logic        o_bus_strobe;
    logic [3:0]  o_bus_cmd;
    logic [3:0]  o_bus_nibble_out;
    logic [19:0] o_pc;
    logic [3:0]  o_nibble;
    logic        o_nibble_valid;
    logic        o_stalled;
    logic        o_fetch_error;

    saturn_fetch_unit dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_en_bus_send    (i_en_bus_send),
        .i_en_bus_recv    (i_en_bus_recv),
        .i_inc_pc         (i_inc_pc),
        .i_stall          (i_stall),
        .i_load_pc        (i_load_pc),
        .i_new_pc         (i_new_pc),
        .i_bus_nibble_in  (i_bus_nibble_in),
        .i_bus_error      (i_bus_error),
        .o_bus_strobe     (o_bus_strobe),
        .o_bus_cmd        (o_bus_cmd),
        .o_bus_nibble_out (o_bus_nibble_out),
        .o_pc             (o_pc),
        .o_nibble         (o_nibble),
        .o_nibble_valid   (o_nibble_valid),
        .o_stalled        (o_stalled),
        .o_fetch_error    (o_fetch_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [19:0] pc;
        logic [3:0]  nib;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: address stream seen by the decoder.
    logic [19:0] m_pc;
    int          m_cnt;     // issue slots left in the current LOAD_PC sequence (7 = CMD next)
    bit          m_pend;    // jump waiting for its issue slot
    bit          m_frozen;
    bit          m_err;

    // Bus slave: remembers the last five address nibbles, auto-increments on reads.
    logic [19:0] s_hist = 20'h0;
    logic [19:0] s_addr = 20'h0;
    bit          s_load = 1'b0;

    function automatic logic [3:0] mem_nib(input logic [19:0] a);
        logic [19:0] t;
        t = a * 20'd13 + (a >> 7) + 20'd5;
        return t[3:0] ^ t[11:8];
    endfunction

    function automatic void push_expect(input logic [19:0] a);
        exp_t e;
        e.pc  = a;
        e.nib = mem_nib(a);
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (o_nibble_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(o_nibble_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_pc", 32'(o_pc), 32'(e.pc));
                check("valid_nibble", 32'(o_nibble), 32'(e.nib));
            end
        end
    end

    task automatic slave_observe();
        if (o_bus_strobe === 1'b1) begin
            if (o_bus_cmd == CMD_LD) begin
                s_hist = {o_bus_nibble_out, s_hist[19:4]};
                s_load = 1'b1;
            end else if (o_bus_cmd == CMD_RD) begin
                if (s_load) s_addr = s_hist;
                s_load          = 1'b0;
                i_bus_nibble_in = mem_nib(s_addr);
                s_addr          = s_addr + 20'd1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        i_reset   = 1'b1;
        i_load_pc = 1'b0;
        i_inc_pc  = 1'b0;
        i_stall   = 1'b0;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < 4; p++) begin
                i_en_bus_send = (p == 0);
                i_en_bus_recv = (p == 1);
                #1;
                check("rst_strobe", 32'(o_bus_strobe), 32'd0);
                check("rst_cmd", 32'(o_bus_cmd), 32'd0);
                check("rst_nibble_out", 32'(o_bus_nibble_out), 32'd0);
                if (c > 0 || p > 0) begin
                    check("rst_nibble", 32'(o_nibble), 32'd0);
                    check("rst_valid", 32'(o_nibble_valid), 32'd0);
                    check("rst_stalled", 32'(o_stalled), 32'd1);
                    check("rst_fetch_error", 32'(o_fetch_error), 32'd0);
                end
                @(negedge i_clk);
            end
        end
        i_reset       = 1'b0;
        i_en_bus_send = 1'b0;
        i_en_bus_recv = 1'b0;
        m_pc          = RESET_PC;
        m_cnt         = 7;
        m_pend        = 1'b0;
        m_frozen      = 1'b0;
        m_err         = 1'b0;
    endtask

    // One CPU cycle: phase 0 issue, phase 1 capture, phase 2 optional early jump,
    // phase 3 optional jump.
    task automatic cpu_cycle(input bit inc, input bit stall, input bit ld, input logic [19:0] npc,
                             input bit ld2, input logic [19:0] npc2, input bit berr);
        bit         exp_strobe;
        bit         exp_stall;
        bit         berr_eff;
        logic [3:0] exp_cmd;
        int         addr_idx;

        exp_strobe = 1'b0;
        exp_cmd    = 4'h0;
        addr_idx   = -1;
        exp_stall  = (m_cnt > 0) || m_pend || stall || m_frozen;
        if (!m_frozen) begin
            if (m_pend) begin
                m_pend = 1'b0;
                m_cnt  = 7;
            end else if (m_cnt > 0) begin
                exp_strobe = 1'b1;
                if (m_cnt == 1) begin
                    exp_cmd = CMD_RD;
                    push_expect(m_pc);
                end else begin
                    exp_cmd = CMD_LD;
                    if (m_cnt <= 6) addr_idx = 6 - m_cnt;
                end
                m_cnt--;
            end else if (inc && !stall) begin
                m_pc       = m_pc + 20'd1;
                exp_strobe = 1'b1;
                exp_cmd    = CMD_RD;
                push_expect(m_pc);
            end
        end
        berr_eff = berr && exp_strobe && (exp_cmd == CMD_RD);

        // phase 0
        i_en_bus_send = 1'b1;
        i_inc_pc      = inc;
        i_stall       = stall;
        #1;
        check("stalled", 32'(o_stalled), 32'(exp_stall));
        check("fetch_error", 32'(o_fetch_error), 32'(m_err));
        check("strobe_issue", 32'(o_bus_strobe), 32'(exp_strobe));
        if (exp_strobe && o_bus_strobe === 1'b1) begin
            check("bus_cmd", 32'(o_bus_cmd), 32'(exp_cmd));
            if (addr_idx >= 0) begin
                check("addr_nibble", 32'(o_bus_nibble_out), 32'((m_pc >> (4 * addr_idx)) & 20'hF));
            end
        end
        slave_observe();
        @(negedge i_clk);

        // phase 1
        i_en_bus_send = 1'b0;
        i_inc_pc      = 1'b0;
        i_en_bus_recv = 1'b1;
        i_bus_error   = berr_eff;
`ifdef FETCH_BUSERR_EN
        if (berr_eff) begin
            m_err    = 1'b1;
            m_frozen = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
`endif
        #1;
        check("strobe_recv", 32'(o_bus_strobe), 32'd0);
        @(negedge i_clk);

        // phase 2
        i_en_bus_recv = 1'b0;
        i_bus_error   = 1'b0;
        if (ld2) begin
            i_load_pc = 1'b1;
            i_new_pc  = npc2;
            m_pc      = npc2;
            m_pend    = 1'b1;
            m_frozen  = 1'b0;
        end
        #1;
        check("strobe_idle", 32'(o_bus_strobe), 32'd0);
        @(negedge i_clk);

        // phase 3
        i_load_pc = 1'b0;
        if (ld) begin
            i_load_pc = 1'b1;
            i_new_pc  = npc;
            m_pc      = npc;
            m_pend    = 1'b1;
            m_frozen  = 1'b0;
        end
        #1;
        check("strobe_exec", 32'(o_bus_strobe), 32'd0);
        @(negedge i_clk);
        i_load_pc = 1'b0;
        i_stall   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cpu_cycle(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cpu_cycle(1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
    endtask

    task automatic jump(input logic [19:0] target);
        cpu_cycle(1'b0, 1'b0, 1'b1, target, 1'b0, 20'h0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r_inc, r_stall, r_ld, r_ld2, r_berr;
        logic [19:0] r_npc, r_npc2;

        i_reset         = 1'b1;
        i_en_bus_send   = 1'b0;
        i_en_bus_recv   = 1'b0;
        i_inc_pc        = 1'b0;
        i_stall         = 1'b0;
        i_load_pc       = 1'b0;
        i_new_pc        = 20'h0;
        i_bus_nibble_in = 4'h0;
        i_bus_error     = 1'b0;
        @(negedge i_clk);

        // Reset release: LOAD_PC of RESET_PC, then first nibble at RESET_PC.
        do_reset(2);
        idle_cycles(8);

        // Sequential fetch.
        run_cycles(3);

        // Stall for three cycles with increments requested, then resume.
        for (int k = 0; k < 3; k++) cpu_cycle(1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
        run_cycles(2);

        // Jump in RUN to 12345.
        jump(20'h12345);
        idle_cycles(8);
        run_cycles(2);

        // Wrap from FFFFF to 00000 without a new LOAD_PC.
        jump(20'hFFFFF);
        idle_cycles(8);
        run_cycles(3);

        // Jump during the address phase restarts with the new target.
        jump(20'h11111);
        idle_cycles(3);
        jump(20'h2468A);
        idle_cycles(8);
        run_cycles(2);

        // Two jumps before one issue slot: the later target wins.
        cpu_cycle(1'b1, 1'b0, 1'b1, 20'h54321, 1'b1, 20'h33333, 1'b0);
        idle_cycles(8);
        run_cycles(2);

        // Jump together with stall: the jump still takes effect.
        cpu_cycle(1'b1, 1'b1, 1'b1, 20'h0BEEF, 1'b0, 20'h0, 1'b0);
        idle_cycles(8);
        run_cycles(2);

        // Reset in the second address slot restarts at RESET_PC.
        jump(20'hABCDE);
        idle_cycles(3);
        do_reset(1);
        idle_cycles(8);
        run_cycles(2);

`ifdef FETCH_BUSERR_EN
        // Bus error freezes fetch until a jump; the flag stays set.
        cpu_cycle(1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b1);
        run_cycles(3);
        jump(20'h00400);
        idle_cycles(8);
        run_cycles(3);
`endif

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            r_inc   = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 7) == 0);
            r_ld    = ($urandom_range(0, 19) == 0);
            r_ld2   = ($urandom_range(0, 59) == 0);
            r_berr  = ($urandom_range(0, 79) == 0);
            r_npc   = ($urandom_range(0, 3) == 0) ? 20'hFFFFD : 20'($urandom);
            r_npc2  = 20'($urandom);
            cpu_cycle(r_inc, r_stall, r_ld, r_npc, r_ld2, r_npc2, r_berr);
        end

        idle_cycles(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
